// File: rtl/uart_rx_cmd_parser.sv
// uart_rx_cmd_parser
// Builds command frames out of the byte strobes that come from the UART receiver,
// then offers each complete command to the system controller over valid/ready.
// Frames, first byte is the opcode:
//   0xAA addr data  -> register write   (cmd_type 00)
//   0xBB addr       -> register read    (cmd_type 01)
//   0xCC A B fun    -> ALU op           (cmd_type 10)
//   0xDD fun        -> ALU op, no args  (cmd_type 11)
// The parser reports three kinds of error:
//   - an unknown opcode
//   - a silent gap inside a frame that is too long
//   - a byte that arrives while a command is still waiting to be accepted

module uart_rx_cmd_parser #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  cmd_ready,
  output logic                  cmd_valid,
  output logic [1:0]            cmd_type,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [DATA_WIDTH-1:0] cmd_op_a,
  output logic [DATA_WIDTH-1:0] cmd_op_b,
  output logic [FUN_WIDTH-1:0]  cmd_fun,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun_err
);

  // Parser states
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] GET_ADDR  = 3'd1;
  localparam logic [2:0] GET_WDATA = 3'd2;
  localparam logic [2:0] GET_OPA   = 3'd3;
  localparam logic [2:0] GET_OPB   = 3'd4;
  localparam logic [2:0] GET_FUN   = 3'd5;
  localparam logic [2:0] HOLD      = 3'd6;

  // Command type encodings
  localparam logic [1:0] TYPE_WR  = 2'b00;
  localparam logic [1:0] TYPE_RD  = 2'b01;
  localparam logic [1:0] TYPE_ALU = 2'b10;
  localparam logic [1:0] TYPE_NOP = 2'b11;

  // Opcode byte values
  localparam logic [DATA_WIDTH-1:0] OPC_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OPC_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OPC_NOP = DATA_WIDTH'(8'hDD);

  // Inter-byte timer
  // The timer counts the silent cycles inside a frame.
  // When it reaches TCNT_LAST and no byte arrives, the frame is abandoned.
  localparam int TCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

  logic [2:0]            state,       state_nxt;
  logic [TCNT_W-1:0]     tcnt,        tcnt_nxt;
  logic                  valid_nxt;
  logic [1:0]            type_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] op_a_nxt;
  logic [DATA_WIDTH-1:0] op_b_nxt;
  logic [FUN_WIDTH-1:0]  fun_nxt;
  logic                  frame_err_nxt;
  logic                  overrun_nxt;
  logic                  take_opcode;
  logic                  in_get;

  assign busy = (state != IDLE);

  // A byte is taken as a new opcode in two cases:
  //   - the parser is idle
  //   - the pending command is accepted in the same cycle that the byte arrives
  assign take_opcode = rx_valid && ((state == IDLE) || ((state == HOLD) && cmd_ready));

  assign in_get = (state == GET_ADDR) || (state == GET_WDATA) || (state == GET_OPA) ||
                  (state == GET_OPB)  || (state == GET_FUN);

  // Next-state logic.
  // It collects the frame fields, runs the handshake, and detects the error events.
  always_comb begin
    state_nxt     = state;
    tcnt_nxt      = tcnt;
    valid_nxt     = cmd_valid;
    type_nxt      = cmd_type;
    addr_nxt      = cmd_addr;
    wdata_nxt     = cmd_wdata;
    op_a_nxt      = cmd_op_a;
    op_b_nxt      = cmd_op_b;
    fun_nxt       = cmd_fun;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;

    case (state)
      GET_ADDR: begin
        if (rx_valid) begin
          addr_nxt = rx_data[ADDR_WIDTH-1:0];
          if (cmd_type == TYPE_WR) begin
            state_nxt = GET_WDATA;
          end else begin
            state_nxt = HOLD;
            valid_nxt = 1'b1;
          end
        end
      end
      GET_WDATA: begin
        if (rx_valid) begin
          wdata_nxt = rx_data;
          state_nxt = HOLD;
          valid_nxt = 1'b1;
        end
      end
      GET_OPA: begin
        if (rx_valid) begin
          op_a_nxt  = rx_data;
          state_nxt = GET_OPB;
        end
      end
      GET_OPB: begin
        if (rx_valid) begin
          op_b_nxt  = rx_data;
          state_nxt = GET_FUN;
        end
      end
      GET_FUN: begin
        if (rx_valid) begin
          fun_nxt   = rx_data[FUN_WIDTH-1:0];
          state_nxt = HOLD;
          valid_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (cmd_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (rx_valid) begin
          overrun_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The timer runs only while a frame is partly collected.
    // A byte that arrives on the expiry cycle still counts, because the rx_valid branch comes first.
    if (in_get) begin
      if (rx_valid) begin
        tcnt_nxt = '0;
      end else if (tcnt == TCNT_LAST) begin
        tcnt_nxt      = '0;
        frame_err_nxt = 1'b1;
        state_nxt     = IDLE;
      end else begin
        tcnt_nxt = tcnt + TCNT_ONE;
      end
    end else begin
      tcnt_nxt = '0;
    end

    // Decode the opcode.
    // This comes last so that it overrides the return to IDLE when the pending command is accepted.
    if (take_opcode) begin
      tcnt_nxt = '0;
      case (rx_data)
        OPC_WR: begin
          type_nxt  = TYPE_WR;
          state_nxt = GET_ADDR;
        end
        OPC_RD: begin
          type_nxt  = TYPE_RD;
          state_nxt = GET_ADDR;
        end
        OPC_ALU: begin
          type_nxt  = TYPE_ALU;
          state_nxt = GET_OPA;
        end
        OPC_NOP: begin
          type_nxt  = TYPE_NOP;
          state_nxt = GET_FUN;
        end
        default: begin
          frame_err_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      endcase
    end
  end

  // State, timer and output registers.
  // Reset clears them all, which discards any partly collected frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      tcnt        <= '0;
      cmd_valid   <= 1'b0;
      cmd_type    <= '0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_op_a    <= '0;
      cmd_op_b    <= '0;
      cmd_fun     <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      cmd_valid   <= valid_nxt;
      cmd_type    <= type_nxt;
      cmd_addr    <= addr_nxt;
      cmd_wdata   <= wdata_nxt;
      cmd_op_a    <= op_a_nxt;
      cmd_op_b    <= op_b_nxt;
      cmd_fun     <= fun_nxt;
      frame_err   <= frame_err_nxt;
      overrun_err <= overrun_nxt;
    end
  end

endmodule
